data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 145 ++++++++++++++
 tb/tb_data_mem_responder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder backed by a
// byte-addressed, little-endian storage array of DEPTH_BYTES bytes.
// A request is accepted in IDLE, waits LATENCY cycles in BUSY, executes,
// and its response is held in RESP until the initiator takes it.
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject misaligned accesses.
module data_mem_responder #(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [3:0]  req_size,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            cap_write;
    logic [AW-1:0]   cap_addr;
    logic [63:0]     cap_wdata;
    logic [3:0]      cap_size;

    logic [7:0]      mem [DEPTH_BYTES];

    logic            size_legal;
    logic            misaligned;
    logic            access_err;
    logic            do_exec;
    logic            do_store;
    logic [7:0]      byte_en;
    logic [AW-1:0]   byte_idx [8];
    logic [63:0]     load_data;

    // Address bits above the array index never affect the access.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^req_addr[63:AW];

    // Ready is combinational so the first edge after reset release can accept.
    assign req_ready = (state == IDLE) && reset;

    // Request checks and per-byte index/enable decode for the captured request.
    always_comb begin
        size_legal = (cap_size == 4'd1) || (cap_size == 4'd2) ||
                     (cap_size == 4'd4) || (cap_size == 4'd8);
`ifdef DMEM_ALIGN_CHECK_EN
        // size-1 on the low three bits gives the alignment mask; size 8 wraps to 7.
        misaligned = (cap_addr[2:0] & (cap_size[2:0] - 3'd1)) != 3'd0;
`else
        misaligned = 1'b0;
`endif
        access_err = !size_legal || misaligned;
        do_exec    = (state == BUSY) && (cnt == '0);
        do_store   = do_exec && cap_write && !access_err;
        load_data  = '0;
        byte_en    = '0;
        for (int k = 0; k < 8; k++) begin
            // Index arithmetic is AW bits wide, so running past the end wraps to 0.
            byte_idx[k]        = cap_addr + AW'(k);
            byte_en[k]         = 4'(k) < cap_size;
            load_data[8*k +: 8] = byte_en[k] ? mem[byte_idx[k]] : 8'h00;
        end
    end

    // Storage array write port: commits exactly the enabled bytes of a legal store.
    // NOTE: the array is deliberately left out of reset; its contents persist
    // across reset and a reset-free RAM maps onto memory macros.
    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int k = 0; k < 8; k++) begin
                if (byte_en[k]) begin
                    mem[byte_idx[k]] <= cap_wdata[8*k +: 8];
                end
            end
        end
    end

    // Control FSM: accept, count down latency, execute, hold response until taken.
    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cap_write  <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_size   <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_write <= req_write;
                        cap_addr  <= req_addr[AW-1:0];
                        cap_wdata <= req_wdata;
                        cap_size  <= req_size;
                        cnt       <= CW'(LATENCY - 1);
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= access_err;
                        resp_rdata <= (cap_write || access_err) ? 64'd0 : load_data;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder. A byte-level reference model
// produces the expected {err, rdata} of each request when it is driven; the
// expectation is queued and compared when the response appears.
// Build with or without DMEM_ALIGN_CHECK_EN; the model follows the same macro.
module tb_data_mem_responder;

    localparam int DEPTH   = 1024;
    localparam int LAT     = 2;
    localparam int TIMEOUT = 50;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [3:0]  req_size;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    int          passed;
    int          total;
    int          cyc;

    logic [7:0]  model_mem [int];
    logic [64:0] sb [$];

    data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_size   (req_size),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, actual, expected);
        end else begin
            passed++;
        end
    endtask

    // Reference model: returns {err, rdata} and updates the model array for stores.
    function automatic logic [64:0] model_access(input bit wr, input logic [63:0] addr,
                                                 input logic [63:0] wdata, input int size);
        logic        err;
        logic [63:0] rdata;
        int          idx;
        err   = !(size == 1 || size == 2 || size == 4 || size == 8);
`ifdef DMEM_ALIGN_CHECK_EN
        if (!err && (addr % size) != 0) err = 1'b1;
`endif
        rdata = '0;
        if (!err) begin
            for (int k = 0; k < size; k++) begin
                idx = int'((addr + 64'(k)) % 64'(DEPTH));
                if (wr) model_mem[idx] = wdata[8*k +: 8];
                else    rdata[8*k +: 8] = model_mem.exists(idx) ? model_mem[idx] : 8'hxx;
            end
            if (wr) rdata = '0;
        end
        return {err, rdata};
    endfunction

    task automatic drive_idle();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_size  = '0;
    endtask

    // Issue one request, check latency and response, optionally stall resp_ready.
    task automatic do_txn(input bit wr, input logic [63:0] addr, input logic [63:0] wdata,
                          input int size, input int hold);
        int          n;
        int          acc;
        logic [64:0] exp;
        logic [63:0] held_rdata;
        logic        held_err;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_size  = 4'(size);
        sb.push_back(model_access(wr, addr, wdata, size));
        n = 0;
        while (!req_ready && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            sb.delete();
            drive_idle();
            return;
        end
        acc = cyc + 1;
        @(posedge clk);
        @(negedge clk);
        // Scramble the request bus so only captured values can matter.
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        req_size  = 4'($urandom);
        n = 0;
        while (!resp_valid && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) begin
            check("resp_timeout", 64'd0, 64'd1);
            sb.delete();
            drive_idle();
            return;
        end
        check("latency", 64'(cyc - acc), 64'(LAT));
        exp = sb.pop_front();
        check("rdata", resp_rdata, exp[63:0]);
        check("err", 64'(resp_err), 64'(exp[64]));
        held_rdata = resp_rdata;
        held_err   = resp_err;
        // While the response is stalled, a pending store must be ignored.
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 64'h10;
            req_wdata = 64'h0;
            req_size  = 4'd8;
            check("stall_req_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
            check("stall_valid", 64'(resp_valid), 64'd1);
            check("stall_rdata", resp_rdata, held_rdata);
            check("stall_err", 64'(resp_err), 64'(held_err));
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        drive_idle();
        check("post_hs_valid", 64'(resp_valid), 64'd0);
        check("post_hs_ready", 64'(req_ready), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_resp_rdata"}, resp_rdata, 64'd0);
        check({tag, "_resp_err"}, 64'(resp_err), 64'd0);
    endtask

    initial begin
        int n;
        passed     = 0;
        total      = 0;
        cyc        = 0;
        reset      = 1'b0;
        resp_ready = 1'b0;
        drive_idle();

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b1;
        #1;
        check("first_ready", 64'(req_ready), 64'd1);

        // Basic store/load, sub-word load, byte store merge.
        do_txn(1'b1, 64'h10, 64'h1122334455667788, 8, 0);
        do_txn(1'b0, 64'h10, 64'h0, 8, 0);
        do_txn(1'b0, 64'h12, 64'h0, 2, 0);
        do_txn(1'b1, 64'h10, 64'hAAAAAAAAAAAAAAFF, 1, 0);
        do_txn(1'b0, 64'h10, 64'h0, 8, 0);

        // Every size code, legal or not, as a load at an aligned address.
        for (int s = 0; s < 16; s++) do_txn(1'b0, 64'h10, 64'h0, s, 0);

        // Stalled response with a request held pending; the held store must not land.
        do_txn(1'b0, 64'h14, 64'h0, 4, 5);
        do_txn(1'b0, 64'h10, 64'h0, 8, 0);

        // Illegal-size store leaves the array untouched.
        do_txn(1'b1, 64'h10, 64'hCAFEF00DCAFEF00D, 3, 0);
        do_txn(1'b0, 64'h10, 64'h0, 8, 0);

        // Misaligned store, then wrap-around at the end of the array.
        do_txn(1'b1, 64'h12, 64'h00000000DEADBEEF, 4, 0);
        do_txn(1'b0, 64'h10, 64'h0, 8, 0);
        do_txn(1'b1, 64'(DEPTH - 4), 64'h00000000A1A2A3A4, 4, 0);
        do_txn(1'b1, 64'h0, 64'h00000000B1B2B3B4, 4, 0);
        do_txn(1'b0, 64'(DEPTH - 4), 64'h0, 8, 0);
        do_txn(1'b1, 64'(DEPTH - 1), 64'h000000000000C2C1, 2, 0);
        do_txn(1'b0, 64'(DEPTH - 4), 64'h0, 4, 0);
        do_txn(1'b0, 64'h0, 64'h0, 4, 0);

        // Reset during BUSY of a store aborts it.
        do_txn(1'b1, 64'h20, 64'h0102030405060708, 8, 0);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h20;
        req_wdata = 64'hFFEEDDCCBBAA9988;
        req_size  = 4'd8;
        n = 0;
        while (!req_ready && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check("abort_accept_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        reset = 1'b0;
        #1;
        check_reset_outputs("busy_rst");
        @(negedge clk);
        reset = 1'b1;
        do_txn(1'b0, 64'h20, 64'h0, 8, 0);

        // Reset during RESP drops the response.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 64'h20;
        req_size  = 4'd8;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        n = 0;
        while (!resp_valid && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check("resp_rst_reached", 64'(resp_valid), 64'd1);
        reset = 1'b0;
        #1;
        check_reset_outputs("resp_rst");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("resp_rst_idle_valid", 64'(resp_valid), 64'd0);
        check("resp_rst_idle_ready", 64'(req_ready), 64'd1);
        do_txn(1'b0, 64'h10, 64'h0, 8, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
